// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Holds the FSM state encoding, owner codes and the timeout data pattern.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IFU = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_e;

    localparam logic ARB_OWNER_IFU = 1'b0;
    localparam logic ARB_OWNER_LSU = 1'b1;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timer.sv
// Busy-cycle counter for the arbiter timeout path.
// Clears on grant, counts enabled cycles, flags when TIMEOUT_CYCLES is reached.
module arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES));

    // Saturates at the limit so a stale count never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between IFU and LSU; LSU-first with a streak limit.
// Optional timeout response when the ARB_TIMEOUT_EN macro is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LSU_MAX_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_reqValid,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_reqValid,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_owner,
    output logic                arb_busy,
    output logic                arb_err
);

    localparam int SW = $clog2(LSU_MAX_STREAK + 1);
    localparam int MW = DATA_W / 8;

    arb_state_e        state_q;
    logic [SW-1:0]     streak_q;
    logic [SW-1:0]     streak_d;
    logic              owner_q;
    logic              req_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     wmask_q;

    logic              busy;
    logic              gnt_ifu;
    logic              gnt_lsu;
    logic              tmo;
    logic              done;
    logic [DATA_W-1:0] rsp_data;

    assign busy = (state_q != ARB_IDLE);

    always_comb begin
        gnt_lsu  = 1'b0;
        gnt_ifu  = 1'b0;
        streak_d = streak_q;
        if (!busy) begin
            if (lsu_reqValid &&
                !(ifu_reqValid && streak_q == SW'(LSU_MAX_STREAK))) begin
                gnt_lsu = 1'b1;
            end else if (ifu_reqValid) begin
                gnt_ifu = 1'b1;
            end
        end
        // Streak only grows while the IFU is actually being starved.
        if (gnt_lsu && ifu_reqValid) begin
            if (streak_q != SW'(LSU_MAX_STREAK)) begin
                streak_d = streak_q + SW'(1);
            end
        end else if (gnt_lsu || gnt_ifu) begin
            streak_d = '0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic expired;

    arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (gnt_ifu | gnt_lsu),
        .en_i     (busy && !mem_respValid),
        .expired_o(expired)
    );

    // A real response in the expiry cycle wins over the timeout.
    assign tmo = busy && expired && !mem_respValid;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = |TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
`endif

    assign done     = busy && (mem_respValid || tmo);
    assign rsp_data = tmo ? DATA_W'(ARB_TIMEOUT_DATA) : mem_rdata;

    assign ifu_respValid = done && (owner_q == ARB_OWNER_IFU);
    assign lsu_respValid = done && (owner_q == ARB_OWNER_LSU);
    assign ifu_rdata     = ifu_respValid ? rsp_data : '0;
    assign lsu_rdata     = lsu_respValid ? rsp_data : '0;
    assign arb_err       = tmo;

    assign mem_reqValid = req_q;
    assign mem_wen      = wen_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign arb_owner    = owner_q;
    assign arb_busy     = req_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
            owner_q  <= ARB_OWNER_IFU;
            req_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            streak_q <= streak_d;
            if (gnt_lsu) begin
                state_q <= ARB_BUSY_LSU;
                owner_q <= ARB_OWNER_LSU;
                req_q   <= 1'b1;
                wen_q   <= lsu_wen;
                addr_q  <= lsu_addr;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else if (gnt_ifu) begin
                state_q <= ARB_BUSY_IFU;
                owner_q <= ARB_OWNER_IFU;
                req_q   <= 1'b1;
                wen_q   <= 1'b0;
                addr_q  <= ifu_addr;
                wdata_q <= '0;
                wmask_q <= '0;
            end else if (done) begin
                state_q <= ARB_IDLE;
                req_q   <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_ifu_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == ARB_BUSY_IFU) |-> ifu_reqValid);
    a_lsu_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == ARB_BUSY_LSU) |-> lsu_reqValid);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory model, IFU/LSU drivers, response monitor.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        arb_owner;
    logic        arb_busy;
    logic        arb_err;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LSU_MAX_STREAK(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner), .arb_busy(arb_busy), .arb_err(arb_err)
    );

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ifu_pulses = 0;
    int   lsu_pulses = 0;
    int   cyc = 0;
    int   mem_delay = 1;
    bit   mem_silent = 0;
    bit   spur = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_5A5A);
    endfunction

    function automatic void push(input logic w, input logic [31:0] d,
                                 input logic e);
        exp_t x;
        x.who = w; x.data = d; x.err = e;
        sb.push_back(x);
    endfunction

    // Memory model: replies mem_delay cycles into a request, or on demand.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_respValid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            mem_respValid = 1'b0;
            mem_rdata = '0;
            if (spur) begin
                mem_respValid = 1'b1;
                mem_rdata = 32'hBAD0_0001;
                spur = 0;
            end else if (mem_reqValid && !mem_silent) begin
                wcnt++;
                if (wcnt >= mem_delay) begin
                    mem_respValid = 1'b1;
                    mem_rdata = rd(mem_addr);
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (ifu_respValid) ifu_pulses++;
            if (lsu_respValid) lsu_pulses++;
            if (ifu_respValid || lsu_respValid) begin
                chk("resp_both", {31'd0, ifu_respValid & lsu_respValid}, 0);
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_who", {31'd0, lsu_respValid}, {31'd0, e.who});
                    chk("resp_data", e.who ? lsu_rdata : ifu_rdata, e.data);
                    chk("resp_err", {31'd0, arb_err}, {31'd0, e.err});
                    chk("nonowner_rdata", e.who ? ifu_rdata : lsu_rdata, 0);
                end
            end else begin
                chk("idle_rdata", ifu_rdata | lsu_rdata, 0);
                chk("idle_err", {31'd0, arb_err}, 0);
            end
        end
    end

    task automatic ifu_run(input logic [31:0] base, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            ifu_reqValid = 1'b1;
            ifu_addr = base + 32'(4 * k);
            got = 0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clock);
                got = ifu_respValid;
            end
            if (!got) chk("ifu_wait", 0, 1);
            @(posedge clock); #1;
        end
        ifu_reqValid = 1'b0;
        ifu_addr = '0;
    endtask

    task automatic lsu_run(input logic [31:0] base, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            lsu_reqValid = 1'b1;
            lsu_wen = 1'b0;
            lsu_addr = base + 32'(4 * k);
            got = 0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clock);
                got = lsu_respValid;
            end
            if (!got) chk("lsu_wait", 0, 1);
            @(posedge clock); #1;
        end
        lsu_reqValid = 1'b0;
        lsu_addr = '0;
    endtask

    initial begin
        bit got;
        int c0;
        int c1;
        reset_n = 1'b0;
        ifu_reqValid = 0; ifu_addr = 0;
        lsu_reqValid = 0; lsu_wen = 0; lsu_addr = 0;
        lsu_wdata = 0; lsu_wmask = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", {31'd0, mem_reqValid}, 0);
        chk("rst_busy", {31'd0, arb_busy}, 0);
        chk("rst_addr", mem_addr, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // IFU alone, slow memory.
        mem_delay = 3;
        ifu_pulses = 0; lsu_pulses = 0;
        push(1'b0, 32'h0000_0413, 1'b0);
        ifu_run(32'h8000_0000, 1);
        @(negedge clock);
        chk("t1_ifu_pulses", ifu_pulses, 1);
        chk("t1_lsu_pulses", lsu_pulses, 0);

        // Store pass-through.
        mem_delay = 1;
        @(posedge clock); #1;
        push(1'b1, rd(32'h8000_0100), 1'b0);
        lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
        @(posedge clock);
        @(negedge clock);
        chk("t2_req", {31'd0, mem_reqValid}, 1);
        chk("t2_wen", {31'd0, mem_wen}, 1);
        chk("t2_addr", mem_addr, 32'h8000_0100);
        chk("t2_wdata", mem_wdata, 32'h1234_5678);
        chk("t2_wmask", {28'd0, mem_wmask}, 32'hF);
        chk("t2_owner", {31'd0, arb_owner}, 1);
        got = lsu_respValid;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            got = lsu_respValid;
        end
        if (!got) chk("t2_wait", 0, 1);
        @(posedge clock); #1;
        lsu_reqValid = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        @(posedge clock); #1;

        // Contention: expected grant order L L L L I L L L L I L.
        for (int k = 0; k < 4; k++) push(1'b1, rd(32'h8000_2000 + 32'(4*k)), 1'b0);
        push(1'b0, rd(32'h8000_1000), 1'b0);
        for (int k = 4; k < 8; k++) push(1'b1, rd(32'h8000_2000 + 32'(4*k)), 1'b0);
        push(1'b0, rd(32'h8000_1004), 1'b0);
        push(1'b1, rd(32'h8000_2020), 1'b0);
        fork
            ifu_run(32'h8000_1000, 2);
            lsu_run(32'h8000_2000, 9);
        join
        chk("t3_sb_drained", sb.size(), 0);
        @(posedge clock); #1;

        // Spurious response while idle.
        @(negedge clock);
        spur = 1;
        @(negedge clock);
        chk("t5_mem_resp", {31'd0, mem_respValid}, 1);
        chk("t5_ifu_resp", {31'd0, ifu_respValid}, 0);
        chk("t5_lsu_resp", {31'd0, lsu_respValid}, 0);
        chk("t5_busy", {31'd0, arb_busy}, 0);

        // Reset while the LSU owns the port.
        mem_silent = 1;
        @(posedge clock); #1;
        lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0300;
        lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
        ifu_reqValid = 1; ifu_addr = 32'h8000_0040;
        @(posedge clock);
        @(negedge clock);
        chk("t4_owner", {31'd0, arb_owner}, 1);
        chk("t4_busy", {31'd0, arb_busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_req", {31'd0, mem_reqValid}, 0);
        chk("t4_rst_busy", {31'd0, arb_busy}, 0);
        chk("t4_rst_owner", {31'd0, arb_owner}, 0);
        chk("t4_rst_addr", mem_addr, 0);
        chk("t4_rst_wdata", mem_wdata, 0);
        chk("t4_rst_misc", {27'd0, mem_wen, mem_wmask}, 0);
        lsu_reqValid = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_silent = 0;
        push(1'b0, rd(32'h8000_0040), 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        ifu_pulses = 0; lsu_pulses = 0;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            got = ifu_respValid;
        end
        if (!got) chk("t4_wait", 0, 1);
        chk("t4_lsu_pulses", lsu_pulses, 0);
        @(posedge clock); #1;
        ifu_reqValid = 0; ifu_addr = 0;
        @(posedge clock); #1;

`ifdef ARB_TIMEOUT_EN
        // Silent memory: forced error response after 16 busy cycles.
        mem_silent = 1;
        push(1'b1, 32'hDEAD_BEEF, 1'b1);
        lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0200;
        c0 = -1; c1 = -1; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            if (mem_reqValid && c0 < 0) c0 = cyc;
            got = lsu_respValid;
            if (got) c1 = cyc;
        end
        if (!got) chk("t6_wait", 0, 1);
        chk("t6_latency", c1 - c0, 16);
        @(posedge clock); #1;
        lsu_reqValid = 0; lsu_addr = 0;
        @(negedge clock);
        chk("t6_req_drop", {31'd0, mem_reqValid}, 0);
        spur = 1;
        @(negedge clock);
        chk("t6_late_mem", {31'd0, mem_respValid}, 1);
        chk("t6_late_lsu", {31'd0, lsu_respValid}, 0);
        mem_silent = 0;
`else
        c0 = 0; c1 = 0;
`endif

        repeat (2) @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
